pc_sequencer: RTL

//  Program-counter sequencer for the fetch stage; supersedes the fixed +4 PC adder.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential advance, stall/flush/redirect
// handling with target alignment checking, and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          INC          = 4,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          ALIGN_BITS   = 2,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow,
  output logic [1:0]      dbg_state
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc_n;
  logic              push, pop, underflow_n;
  logic [XLEN-1:0]   ras [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     count;
  logic [PW-1:0]     top_idx;
  logic [XLEN-1:0]   redirect_target;

  assign top_idx         = ptr - PW'(1);
  assign redirect_target = branch_taken ? branch_target : jump_target;

  assign pc_valid   = (state == RUN);
  assign misaligned = (state == FAULT);
  assign ras_empty  = (count == '0);
  assign ras_full   = (count == CW'(RAS_DEPTH));
  assign dbg_state  = state;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    push        = 1'b0;
    pop         = 1'b0;
    underflow_n = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (flush) begin
          pc_n = flush_target;
        end else if (branch_taken || jump) begin
          if ((redirect_target & ALIGN_MASK) != '0) begin
            state_n = FAULT;
          end else begin
            pc_n = redirect_target;
            push = jump && call;
          end
        end else if (stall) begin
          pc_n = pc;
        end else if (ret) begin
          if (!ras_empty) begin
            pc_n = ras[top_idx];
            pop  = 1'b1;
          end else begin
            pc_n        = pc + INC_V;
            underflow_n = 1'b1;
          end
        end else begin
          pc_n = pc + INC_V;
        end
      end
      FAULT: begin
        if (flush) begin
          state_n = RUN;
          pc_n    = flush_target;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      pc_plus_inc   <= RESET_VECTOR + INC_V;
      ras_underflow <= 1'b0;
      ptr           <= '0;
      count         <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      pc_plus_inc   <= pc_n + INC_V;
      ras_underflow <= underflow_n;
      // A push into a full stack overwrites the oldest entry; count saturates.
      if (push) begin
        ptr <= ptr + PW'(1);
        if (!ras_full) count <= count + CW'(1);
      end else if (pop) begin
        ptr   <= top_idx;
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage carries no reset; count alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push) ras[ptr] <= pc_plus_inc;
  end

endmodule
